pulse_handshake_tx: RTL and testbench
=====================================

PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 Parameter SYNC_STAGES, 2, number of flops synchronizing i_ack (legal 2..4).
REQ-002 Parameter CNT_W, 4, width of pending-pulse counter (legal 1..8).
REQ-003 i_fast_clk  input  1  sole clock; all logic rising-edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_pulse  input  1  single-cycle event from the fast domain.
REQ-006 i_ack  input  1  level acknowledge from slow-domain receiver; asynchronous to i_fast_clk.
REQ-007 i_clr_ovf  input  1  synchronous clear of o_overflow.
REQ-008 o_req  output  1  registered level request to slow domain.
REQ-009 o_busy  output  1  high whenever state is not IDLE.
REQ-010 o_pending  output  CNT_W  count of accepted pulses not yet launched.
REQ-011 o_done  output  1  one-cycle pulse per completed four-phase handshake.
REQ-012 o_overflow  output  1  sticky flag: at least one pulse dropped.

Function
REQ-013 Internal ack_s SHALL be i_ack delayed through SYNC_STAGES flops; no other logic SHALL sample i_ack.
REQ-014 FSM states SHALL be IDLE, REQ_HI (o_req=1), ACK_WAIT_LO (o_req=0); o_req SHALL be a registered state decode.
REQ-015 IDLE->REQ_HI when (i_pulse=1 or o_pending>0) and ack_s=0; o_req high on the edge after the accepting cycle (1-cycle latency).
REQ-016 REQ_HI->ACK_WAIT_LO when ack_s=1; o_done SHALL pulse high for exactly the cycle after this transition.
REQ-017 ACK_WAIT_LO->REQ_HI when ack_s=0 and (o_pending>0 or i_pulse=1); ->IDLE when ack_s=0 and no work; else stay.
REQ-018 A pulse consumed directly by an IDLE->REQ_HI or ACK_WAIT_LO->REQ_HI launch SHALL NOT increment o_pending; otherwise o_pending launches SHALL decrement it by 1.
REQ-019 A pulse arriving while a handshake is in flight, or in IDLE while ack_s=1, SHALL increment o_pending.
REQ-020 Simultaneous increment and decrement SHALL leave o_pending unchanged.
REQ-021 o_pending SHALL saturate at 2^CNT_W-1; a pulse arriving at saturation (without same-cycle decrement) SHALL be dropped and set o_overflow.
REQ-022 o_overflow SHALL clear on i_clr_ovf=1 unless a drop occurs the same cycle (set wins).
REQ-023 A new request SHALL never be raised while ack_s=1 (four-phase rule).

Reset
REQ-024 i_rst=1 SHALL immediately force state IDLE, o_req=0, o_busy=0, o_pending=0, o_done=0, o_overflow=0, synchronizer flops=0.
REQ-025 Reset mid-handshake SHALL drop all pending pulses; after release, REQ-015 ack_s=0 gating SHALL hold off new requests until receiver ack clears.
REQ-026 i_rst deassertion is assumed synchronized externally to i_fast_clk.

Structure
REQ-027 State enum typedef and default SYNC_STAGES/CNT_W constants SHALL live in package pulse_synch_pkg.
REQ-028 The ack synchronizer SHALL be sub-module bit_synch (parameter STAGES, async active-high reset).

Verification
REQ-029 Single pulse, i_ack mirrors o_req after 3 cycles -> o_req high 1 cycle after pulse, o_done once, o_pending stays 0, o_busy low after ack_s falls.
REQ-030 Three pulses 2 cycles apart during one handshake -> o_pending 1,2,3 then three further handshakes, o_done total 4, o_pending ends 0.
REQ-031 CNT_W=4, i_ack held 0, 17 pulses -> o_pending=15, o_overflow=1 after 17th; i_clr_ovf clears it, o_pending unchanged.
REQ-032 Pulse coincident with a pending decrement at o_pending=5 -> o_pending remains 5.
REQ-033 i_rst asserted in REQ_HI with o_pending=3 -> o_req=0 same cycle, all outputs reset; i_ack held 1 after release plus a pulse -> o_pending=1, no o_req until i_ack=0.
REQ-034 Pulse arriving exactly in cycle ack_s falls in ACK_WAIT_LO -> direct relaunch, o_pending not incremented, o_busy stays high.

Source files
------------

// File: rtl/pulse_synch_pkg.sv
// Shared types and default sizing for the fast-to-slow pulse handshake transmitter.
package pulse_synch_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ_HI      = 2'd1,
    ST_ACK_WAIT_LO = 2'd2
  } hs_state_e;

  // A launch is any entry into REQ_HI from a state that was not already requesting.
  function automatic logic is_launch(input hs_state_e cur, input hs_state_e nxt);
    return (nxt == ST_REQ_HI) && (cur != ST_REQ_HI);
  endfunction

endpackage

// File: rtl/pulse_handshake_tx_if.sv
// Pulse/acknowledge bundle between the fast-domain event source, the transmitter
// and the slow-domain receiver. The transmitter takes the master side.
interface pulse_handshake_tx_if
  import pulse_synch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             i_pulse;
  logic             i_ack;
  logic             i_clr_ovf;
  logic             o_req;
  logic             o_busy;
  logic [CNT_W-1:0] o_pending;
  logic             o_done;
  logic             o_overflow;

  modport master (
    input  i_pulse, i_ack, i_clr_ovf,
    output o_req, o_busy, o_pending, o_done, o_overflow
  );

  modport slave (
    output i_pulse, i_ack, i_clr_ovf,
    input  o_req, o_busy, o_pending, o_done, o_overflow
  );

endinterface

// File: rtl/bit_synch.sv
// Multi-flop single-bit synchronizer; output is the last flop of the chain.
module bit_synch #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Carries single-cycle fast-domain events across to a slow receiver with a
// four-phase req/ack handshake, queueing events that arrive while busy.
module pulse_handshake_tx
  import pulse_synch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                  i_fast_clk,
  input logic                  i_rst,
  pulse_handshake_tx_if.master hs
);

  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};

  hs_state_e        state_r;
  hs_state_e        state_s;
  logic             ack_s;
  logic             work_s;
  logic             launch_s;
  logic             drop_s;
  logic             ovf_s;
  logic [CNT_W-1:0] pend_s;
  logic [CNT_W-1:0] pend_r;
  logic             req_r;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;

  bit_synch #(.STAGES(SYNC_STAGES)) u_ack_synch (
    .clk (i_fast_clk),
    .rst (i_rst),
    .d   (hs.i_ack),
    .q   (ack_s)
  );

  // next-state: a request is only ever raised while the synchronized ack is low
  always_comb begin
    state_s = state_r;
    work_s  = hs.i_pulse || (pend_r != PEND_ZERO);
    case (state_r)
      ST_IDLE: begin
        if (work_s && !ack_s) state_s = ST_REQ_HI;
        else                  state_s = ST_IDLE;
      end
      ST_REQ_HI: begin
        if (ack_s) state_s = ST_ACK_WAIT_LO;
        else       state_s = ST_REQ_HI;
      end
      ST_ACK_WAIT_LO: begin
        if (ack_s)       state_s = ST_ACK_WAIT_LO;
        else if (work_s) state_s = ST_REQ_HI;
        else             state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // pending count: a pulse coinciding with a launch is consumed by it directly
  always_comb begin
    launch_s = is_launch(state_r, state_s);
    pend_s   = pend_r;
    drop_s   = 1'b0;
    ovf_s    = ovf_r;
    if (launch_s && !hs.i_pulse) begin
      pend_s = pend_r - PEND_ONE;
    end else if (!launch_s && hs.i_pulse) begin
      if (pend_r == PEND_MAX) drop_s = 1'b1;
      else                    pend_s = pend_r + PEND_ONE;
    end else begin
      pend_s = pend_r;
    end
    if (drop_s)             ovf_s = 1'b1;
    else if (hs.i_clr_ovf)  ovf_s = 1'b0;
    else                    ovf_s = ovf_r;
  end

  // state register and registered decodes of the next state
  always_ff @(posedge i_fast_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pend_r  <= PEND_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= (state_s == ST_REQ_HI);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_r == ST_REQ_HI) && (state_s == ST_ACK_WAIT_LO);
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
    end
  end

  assign hs.o_req      = req_r;
  assign hs.o_busy     = busy_r;
  assign hs.o_pending  = pend_r;
  assign hs.o_done     = done_r;
  assign hs.o_overflow = ovf_r;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Scenario bench for pulse_handshake_tx: expected pending counts are queued as
// pulses are driven and compared when the DUT has registered them.
module tb_pulse_handshake_tx;

  logic       i_fast_clk;
  logic       i_rst;
  logic       auto_ack;
  logic       man_ack;
  logic [2:0] ack_pipe;
  int         n_chk;
  int         n_fail;
  int         done_cnt;
  int         exp_pend_q[$];

  pulse_handshake_tx_if #(.CNT_W(4)) hs ();

  pulse_handshake_tx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .i_fast_clk (i_fast_clk),
    .i_rst      (i_rst),
    .hs         (hs)
  );

  initial i_fast_clk = 1'b0;
  always #5 i_fast_clk = ~i_fast_clk;

  // receiver model: ack follows req with a few cycles of delay
  always @(negedge i_fast_clk) begin
    if (auto_ack) ack_pipe = {ack_pipe[1:0], hs.o_req};
    else          ack_pipe = 3'b000;
  end
  assign hs.i_ack = auto_ack ? ack_pipe[2] : man_ack;

  task automatic tick();
    @(negedge i_fast_clk);
    if (hs.o_done === 1'b1) done_cnt++;
  endtask

  task automatic drive_pulse(input int exp_pend);
    hs.i_pulse = 1'b1;
    exp_pend_q.push_back(exp_pend);
    tick();
    hs.i_pulse = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0;
    hs.i_pulse = 1'b0; hs.i_clr_ovf = 1'b0;
    exp_pend_q.delete();
    tick(); tick();
    i_rst = 1'b0;
    tick();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_chk++; if (hs.o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", hs.o_req); end
    n_chk++; if (hs.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", hs.o_busy); end
    n_chk++; if (hs.o_pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", hs.o_pending); end
    n_chk++; if (hs.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", hs.o_done); end
    n_chk++; if (hs.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", hs.o_overflow); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int budget;
    int e;
    logic done_with_req;
    done_with_req = 1'b0;
    auto_ack = 1'b1;
    done_cnt = 0;
    drive_pulse(0);
    e = exp_pend_q.pop_front();
    n_chk++; if (hs.o_req !== 1'b1) begin n_fail++; $display("FAIL single_req_latency: got %0b expected 1", hs.o_req); end
    n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL single_pending: got %0d expected %0d", hs.o_pending, e); end
    budget = 40;
    while (hs.o_busy === 1'b1 && budget > 0) begin
      tick();
      if (hs.o_done === 1'b1 && hs.o_req === 1'b1) done_with_req = 1'b1;
      budget--;
    end
    n_chk++; if (budget == 0) begin n_fail++; $display("FAIL single_timeout: got busy %0b expected 0", hs.o_busy); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
    n_chk++; if (done_with_req !== 1'b0) begin n_fail++; $display("FAIL single_done_phase: got req high with done, expected low"); end
    n_chk++; if (hs.o_pending !== 4'd0) begin n_fail++; $display("FAIL single_pending_end: got %0d expected 0", hs.o_pending); end
  endtask

  task automatic test_queue();
    int budget;
    int e;
    auto_ack = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      drive_pulse(k);
      e = exp_pend_q.pop_front();
      n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL queue_pending_%0d: got %0d expected %0d", k, hs.o_pending, e); end
      tick();
    end
    budget = 200;
    while (hs.o_busy === 1'b1 && budget > 0) begin tick(); budget--; end
    n_chk++; if (budget == 0) begin n_fail++; $display("FAIL queue_timeout: got busy %0b expected 0", hs.o_busy); end
    n_chk++; if (done_cnt !== 4) begin n_fail++; $display("FAIL queue_done_count: got %0d expected 4", done_cnt); end
    n_chk++; if (hs.o_pending !== 4'd0) begin n_fail++; $display("FAIL queue_pending_end: got %0d expected 0", hs.o_pending); end
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive_pulse(k == 1 ? 0 : (k - 1 > 15 ? 15 : k - 1));
      e = exp_pend_q.pop_front();
      n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL ovf_pending_%0d: got %0d expected %0d", k, hs.o_pending, e); end
      if (k == 16) begin
        n_chk++; if (hs.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b expected 0", hs.o_overflow); end
      end
    end
    n_chk++; if (hs.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", hs.o_overflow); end
    hs.i_clr_ovf = 1'b1;
    tick();
    hs.i_clr_ovf = 1'b0;
    n_chk++; if (hs.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", hs.o_overflow); end
    n_chk++; if (hs.o_pending !== 4'd15) begin n_fail++; $display("FAIL ovf_clear_pending: got %0d expected 15", hs.o_pending); end
    hs.i_clr_ovf = 1'b1;
    drive_pulse(15);
    hs.i_clr_ovf = 1'b0;
    e = exp_pend_q.pop_front();
    n_chk++; if (hs.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0b expected 1", hs.o_overflow); end
    n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL ovf_set_wins_pending: got %0d expected %0d", hs.o_pending, e); end
  endtask

  task automatic test_ack_fall_pulse(input int preload);
    int budget;
    int e;
    do_reset();
    for (int k = 0; k <= preload; k++) begin
      drive_pulse(k);
      e = exp_pend_q.pop_front();
      n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL fall%0d_preload_%0d: got %0d expected %0d", preload, k, hs.o_pending, e); end
    end
    man_ack = 1'b1;
    budget = 10;
    while (hs.o_done !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_chk++; if (budget == 0) begin n_fail++; $display("FAIL fall%0d_done_timeout: got done %0b expected 1", preload, hs.o_done); end
    man_ack = 1'b0;
    tick();
    n_chk++; if (hs.o_busy !== 1'b1) begin n_fail++; $display("FAIL fall%0d_busy_a: got %0b expected 1", preload, hs.o_busy); end
    tick();
    n_chk++; if (hs.o_req !== 1'b0) begin n_fail++; $display("FAIL fall%0d_req_low: got %0b expected 0", preload, hs.o_req); end
    n_chk++; if (hs.o_pending !== 4'(preload)) begin n_fail++; $display("FAIL fall%0d_pend_before: got %0d expected %0d", preload, hs.o_pending, preload); end
    drive_pulse(preload);
    e = exp_pend_q.pop_front();
    n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL fall%0d_pend_after: got %0d expected %0d", preload, hs.o_pending, e); end
    n_chk++; if (hs.o_req !== 1'b1) begin n_fail++; $display("FAIL fall%0d_relaunch: got %0b expected 1", preload, hs.o_req); end
    n_chk++; if (hs.o_busy !== 1'b1) begin n_fail++; $display("FAIL fall%0d_busy_b: got %0b expected 1", preload, hs.o_busy); end
  endtask

  task automatic test_reset_mid();
    int budget;
    int e;
    logic saw_req;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_pulse(k);
      e = exp_pend_q.pop_front();
      n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL rstmid_pending_%0d: got %0d expected %0d", k, hs.o_pending, e); end
    end
    n_chk++; if (hs.o_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req: got %0b expected 1", hs.o_req); end
    i_rst = 1'b1;
    man_ack = 1'b1;
    #1;
    n_chk++; if (hs.o_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %0b expected 0", hs.o_req); end
    n_chk++; if (hs.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", hs.o_busy); end
    n_chk++; if (hs.o_pending !== 4'd0) begin n_fail++; $display("FAIL rstmid_pending: got %0d expected 0", hs.o_pending); end
    n_chk++; if (hs.o_done !== 1'b0 || hs.o_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got done %0b ovf %0b expected 0 0", hs.o_done, hs.o_overflow); end
    tick(); tick();
    i_rst = 1'b0;
    tick(); tick(); tick();
    drive_pulse(1);
    e = exp_pend_q.pop_front();
    n_chk++; if (hs.o_pending !== 4'(e)) begin n_fail++; $display("FAIL rstmid_held_pending: got %0d expected %0d", hs.o_pending, e); end
    saw_req = hs.o_req;
    for (int k = 0; k < 5; k++) begin tick(); if (hs.o_req === 1'b1) saw_req = 1'b1; end
    n_chk++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_held: got %0b expected 0", saw_req); end
    n_chk++; if (hs.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_held: got %0b expected 0", hs.o_busy); end
    man_ack = 1'b0;
    budget = 10;
    while (hs.o_req !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_chk++; if (budget == 0) begin n_fail++; $display("FAIL rstmid_launch_timeout: got req %0b expected 1", hs.o_req); end
    n_chk++; if (hs.o_pending !== 4'd0) begin n_fail++; $display("FAIL rstmid_launch_pending: got %0d expected 0", hs.o_pending); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0;
    i_rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0; ack_pipe = 3'b000;
    hs.i_pulse = 1'b0; hs.i_clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_ack_fall_pulse(5);
    test_ack_fall_pulse(0);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
